mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Initiator side of the data-memory interface, in the MEM stage between the pipeline and data_mem.
//  Turns one load/store request (LB/LBU/LH/LHU/LW/SB/SH/SW) into ce/we/addr/wdata cycles.
//  Returns the extended load result and a completion pulse, and raises stall_req while busy.
//  Sub-word stores are done as read-modify-write, because data_mem only writes whole words.
//  Memory is big-endian: byte lane k = addr[1:0] occupies bits [31-8k -: 8].
// PARAMETERS
//  ADDR_W   32    width of req_addr / mem_addr (byte address; data_mem indexes by addr>>2)
//  DATA_W   32    word width; fixed at 32, no other value is supported
// PORTS
//  clk        in   1       single clock; all state updates on posedge
//  rst        in   1       synchronous, active-high reset
//  req_valid  in   1       request present; requester holds all req_* stable until done
//  req_op     in   4       0:LB 1:LBU 2:LH 3:LHU 4:LW 8:SB 9:SH 10:SW; any other code is invalid
//  req_addr   in   ADDR_W  byte address
//  req_wdata  in   32      store data; SB uses [7:0], SH uses [15:0]
//  stall_req  out  1       hold the pipeline (combinational)
//  done       out  1       one-cycle completion pulse (registered)
//  result     out  32      load result, valid while done=1 (registered)
//  err        out  1       misaligned address or invalid op, valid while done=1 (registered)
//  mem_ce     out  1       data_mem chip enable
//  mem_we     out  1       data_mem write enable
//  mem_addr   out  ADDR_W  data_mem address
//  mem_wdata  out  32      data_mem write data
//  mem_rdata  in   32      data_mem read data; combinational from mem_addr while ce=1 and we=0
// BEHAVIOUR
//  Reset
//   - state=IDLE, done=0, result=0, err=0.
//   - mem_ce, mem_we, mem_addr, mem_wdata all 0 while in IDLE.
//   - mem_ce and mem_we are gated by ~rst: no write occurs in any cycle with rst=1, even mid-RMW.
//  States: IDLE, RD, WR, DONE.
//  IDLE
//   - req_valid=0: stay in IDLE.
//   - req_valid=1: latch op, addr and wdata.
//   - Misaligned request (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) or invalid op:
//     go to DONE with err=1. No memory access is made.
//   - Otherwise, loads and SB/SH go to RD; SW goes to WR.
//  RD
//   - Drive mem_ce=1, mem_we=0, mem_addr={addr[ADDR_W-1:2],2'b00}.
//   - Load ops: at the clock edge, extract the lane and go to DONE.
//     LB/LH sign-extend; LBU/LHU zero-extend.
//     Halfword with addr[1]=0 takes [31:16]; with addr[1]=1 takes [15:0].
//   - SB/SH: at the clock edge, capture mem_rdata into the merge register and go to WR.
//  WR
//   - Drive mem_ce=1, mem_we=1, mem_addr=word address.
//   - SW: mem_wdata = latched wdata.
//   - SB/SH: mem_wdata = merged word; only the target lane is replaced.
//   - The write commits at the clock edge that leaves WR. Go to DONE.
//  DONE
//   - done=1 for exactly one cycle, with result and err valid. Then go to IDLE.
//   - result=0 for stores and errors.
//   - req_valid is ignored in DONE; a new request is accepted from IDLE the next cycle.
//  stall_req = (state==IDLE & req_valid) | state==RD | state==WR.
//   - It is 0 in DONE, so the pipeline advances on the same edge that done is sampled.
//  Latency, with the request seen in IDLE at cycle N:
//   - loads and SW: done at N+2.
//   - SB/SH: done at N+3.
//   - err: done at N+1.
//  done, result and err stay 0 outside DONE.
//  Reset asserted in any state: back to IDLE at the next edge, with no done pulse.
// TESTING
//  1 rst=1 for 2 cycles -> all outputs 0, mem_ce=0; then req_valid=0 for 5 cycles -> no mem_ce activity.
//  2 SW addr=0x10 data=0xDEADBEEF, then LW 0x10 -> mem_we high 1 cycle; done at N+2; result=0xDEADBEEF.
//  3 SB addr=0x11 data=0x55 over 0xDEADBEEF -> RD then WR cycle; word becomes 0xDE55BEEF.
//    Then LB 0x11 -> 0x00000055; LB 0x10 -> 0xFFFFFFDE; LBU 0x10 -> 0x000000DE.
//  4 SH 0x12 data=0x8001, then LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001.
//  5 LW 0x13 and SH 0x11 -> err=1, done at N+1, mem_ce never 1; memory unchanged.
//    Invalid op 5 -> err=1.
//  6 SB 0x20 with rst asserted during the WR cycle -> mem_we=0 that cycle.
//    Word at 0x20 unchanged, no done pulse, state IDLE.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator for data_mem: sequences load/store requests into ce/we/addr/wdata
// cycles, with read-modify-write for sub-word stores on a big-endian, word-only memory.
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall_req,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              err,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_SB  = 4'd8,
    OP_SH  = 4'd9,
    OP_SW  = 4'd10
  } op_e;

  state_e            state;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merge_q;

  logic              req_bad;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merged;

  always_comb begin
    req_bad = 1'b0;
    case (req_op)
      OP_LB, OP_LBU, OP_SB: req_bad = 1'b0;
      OP_LH, OP_LHU, OP_SH: req_bad = req_addr[0];
      OP_LW, OP_SW:         req_bad = |req_addr[1:0];
      default:              req_bad = 1'b1;
    endcase
  end

  // Lane k of a big-endian word sits at bits [31-8k -: 8].
  always_comb begin
    byte_v = mem_rdata[31:24];
    case (addr_q[1:0])
      2'd0: byte_v = mem_rdata[31:24];
      2'd1: byte_v = mem_rdata[23:16];
      2'd2: byte_v = mem_rdata[15:8];
      2'd3: byte_v = mem_rdata[7:0];
      default: byte_v = mem_rdata[31:24];
    endcase
    half_v = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    load_val = '0;
    case (op_q)
      OP_LB:   load_val = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_val = {24'd0, byte_v};
      OP_LH:   load_val = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_val = {16'd0, half_v};
      OP_LW:   load_val = mem_rdata;
      default: load_val = '0;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (op_q == OP_SB) begin
      case (addr_q[1:0])
        2'd0: merged[31:24] = wdata_q[7:0];
        2'd1: merged[23:16] = wdata_q[7:0];
        2'd2: merged[15:8]  = wdata_q[7:0];
        2'd3: merged[7:0]   = wdata_q[7:0];
        default: merged = mem_rdata;
      endcase
    end else if (op_q == OP_SH) begin
      if (addr_q[1]) merged[15:0]  = wdata_q[15:0];
      else           merged[31:16] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      result  <= '0;
      err     <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
    end else begin
      done   <= 1'b0;
      result <= '0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (req_bad) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (req_op == OP_SW) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (op_q[3]) begin
            merge_q <= merged;
            state   <= WR;
          end else begin
            result <= load_val;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        WR: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are gated by rst so a reset landing mid-RMW never commits a write.
  always_comb begin
    mem_ce    = (state == RD || state == WR) && !rst;
    mem_we    = (state == WR) && !rst;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == RD || state == WR) mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    if (state == WR) mem_wdata = (op_q == OP_SW) ? wdata_q : merge_q;
  end

  assign stall_req = (state == IDLE && req_valid) || state == RD || state == WR;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl against a small word-addressed memory model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall_req;
  logic        done;
  logic [31:0] result;
  logic        err;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        tb_init;
  logic [31:0] mem [64];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ce_cnt = 0;
  int we_cnt = 0;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        err;
    int          lat;
    int          ce;
    int          we;
    int          t0;
  } exp_t;

  exp_t exp_q[$];

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall_req(stall_req),
    .done(done), .result(result), .err(err), .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always_comb mem_rdata = (mem_ce && !mem_we) ? mem[mem_addr[7:2]] : 32'd0;

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A5_0000 | i;
    end else if (mem_ce && mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      ce_cnt = 0;
      we_cnt = 0;
    end
  end

  function automatic void chk(string n, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endfunction

  // Monitor: counts memory strobes and checks each done pulse against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mem_ce) ce_cnt++;
      if (mem_we) we_cnt++;
      if (mem_ce && mem_addr[31:8] != 24'd0) chk("mem_addr range", mem_addr, mem_addr & 32'hFF);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected done", {31'd0, done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, " result"}, result, e.res);
          chk({e.name, " err"}, {31'd0, err}, {31'd0, e.err});
          chk({e.name, " latency"}, cyc - e.t0, e.lat);
          chk({e.name, " ce cycles"}, ce_cnt, e.ce);
          chk({e.name, " we cycles"}, we_cnt, e.we);
          chk({e.name, " stall in done"}, {31'd0, stall_req}, 32'd0);
        end
        ce_cnt = 0;
        we_cnt = 0;
      end
    end
  end

  task automatic do_req(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] er, input logic ee,
                        input int lat, input int ce, input int we);
    exp_t e;
    bit   seen;
    @(negedge clk);
    e.name = name; e.res = er; e.err = ee; e.lat = lat; e.ce = ce; e.we = we; e.t0 = cyc;
    exp_q.push_back(e);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      chk({name, " timeout"}, 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tb_init = 1'b1; req_valid = 1'b0;
    req_op = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst err", {31'd0, err}, 32'd0);
    chk("rst mem_ce", {31'd0, mem_ce}, 32'd0);
    chk("rst mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0; tb_init = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle mem_ce", {31'd0, mem_ce}, 32'd0);
      chk("idle stall", {31'd0, stall_req}, 32'd0);
    end

    do_req("SW 10", 4'd10, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 1);
    chk("mem after SW", mem[4], 32'hDEADBEEF);
    do_req("LW 10", 4'd4, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0);

    do_req("SB 11", 4'd8, 32'h11, 32'hFFFF_FF55, 32'h0, 1'b0, 3, 2, 1);
    chk("mem after SB", mem[4], 32'hDE55BEEF);
    do_req("LB 11", 4'd0, 32'h11, 32'h0, 32'h00000055, 1'b0, 2, 1, 0);
    do_req("LB 10", 4'd0, 32'h10, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 1, 0);
    do_req("LBU 10", 4'd1, 32'h10, 32'h0, 32'h000000DE, 1'b0, 2, 1, 0);

    do_req("SH 12", 4'd9, 32'h12, 32'h1234_8001, 32'h0, 1'b0, 3, 2, 1);
    chk("mem after SH", mem[4], 32'hDE558001);
    do_req("LH 12", 4'd2, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, 2, 1, 0);
    do_req("LHU 12", 4'd3, 32'h12, 32'h0, 32'h00008001, 1'b0, 2, 1, 0);
    do_req("LH 10", 4'd2, 32'h10, 32'h0, 32'hFFFFDE55, 1'b0, 2, 1, 0);
    do_req("LB 13", 4'd0, 32'h13, 32'h0, 32'h00000001, 1'b0, 2, 1, 0);
    do_req("LBU 12", 4'd1, 32'h12, 32'h0, 32'h00000080, 1'b0, 2, 1, 0);

    do_req("LW 13 misalign", 4'd4, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("SH 11 misalign", 4'd9, 32'h11, 32'hBEEF, 32'h0, 1'b1, 1, 0, 0);
    do_req("SW 12 misalign", 4'd10, 32'h12, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("op 5 invalid", 4'd5, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    chk("mem after errs", mem[4], 32'hDE558001);

    // Reset during the write phase of a byte RMW.
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd8; req_addr = 32'h20; req_wdata = 32'h77;
    @(negedge clk);
    chk("t6 RD ce", {31'd0, mem_ce}, 32'd1);
    chk("t6 RD we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    chk("t6 WR we before rst", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6 WR we under rst", {31'd0, mem_we}, 32'd0);
    chk("t6 WR ce under rst", {31'd0, mem_ce}, 32'd0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    chk("t6 idle stall", {31'd0, stall_req}, 32'd0);
    chk("t6 idle mem_ce", {31'd0, mem_ce}, 32'd0);
    repeat (3) @(negedge clk);
    chk("t6 no done", {31'd0, done}, 32'd0);
    chk("t6 mem unchanged", mem[8], 32'hA5A50008);
    do_req("LW 20 after rst", 4'd4, 32'h20, 32'h0, 32'hA5A50008, 1'b0, 2, 1, 0);

    repeat (2) @(negedge clk);
    chk("queue drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
